// File: rtl/pc_fetch_unit.sv
// Program-counter unit for the IF stage: valid/ready fetch request, stall, branch/trap redirects with queuing.
// Optional build macro PC_ALIGN_CHECK_EN aligns redirect targets to INSTR_BYTES and flags misaligned ones.
module pc_fetch_unit #(
  parameter int              PC_W         = 64,
  parameter int              INSTR_BYTES  = 4,
  parameter logic [PC_W-1:0] RESET_VECTOR = {PC_W{1'b0}}
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            trap,
  input  logic [PC_W-1:0] trap_vector,
  input  logic            fetch_ready,
  output logic            fetch_valid,
  output logic [PC_W-1:0] PC_Out,
  output logic [PC_W-1:0] PC_Next_Seq,
  output logic            redirect_pending,
  output logic            misaligned
);

  typedef enum logic [1:0] {
    BOOT       = 2'd0,
    RUN        = 2'd1,
    REDIR_WAIT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pend_target_q, pend_target_d;
  logic            fetch_valid_q, fetch_valid_d;
  logic            redirect_pending_q, redirect_pending_d;
  logic            misaligned_q, misaligned_d;

  logic            redir_s;
  logic [PC_W-1:0] tgt_raw_s;
  logic [PC_W-1:0] tgt_s;
  logic            tgt_mis_s;

  // Trap has priority over a branch raised in the same cycle.
  assign redir_s   = trap | branch_taken;
  assign tgt_raw_s = trap ? trap_vector : branch_target;

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [PC_W-1:0] ALIGN_MASK = PC_W'(INSTR_BYTES - 1);
  assign tgt_s     = tgt_raw_s & ~ALIGN_MASK;
  assign tgt_mis_s = |(tgt_raw_s & ALIGN_MASK);
`else
  assign tgt_s     = tgt_raw_s;
  assign tgt_mis_s = 1'b0;
`endif

  assign PC_Next_Seq = pc_q + PC_W'(INSTR_BYTES);

  // Next-state and next-register computation for the fetch FSM.
  always_comb begin
    state_d            = state_q;
    pc_d               = pc_q;
    pend_target_d      = pend_target_q;
    fetch_valid_d      = fetch_valid_q;
    redirect_pending_d = redirect_pending_q;
    misaligned_d       = 1'b0;
    case (state_q)
      BOOT: begin
        state_d       = RUN;
        fetch_valid_d = 1'b1;
      end
      RUN: begin
        if (fetch_ready) begin
          if (redir_s) begin
            pc_d         = tgt_s;
            misaligned_d = tgt_mis_s;
          end else if (!stall) begin
            pc_d = PC_Next_Seq;
          end else begin
            pc_d = pc_q;
          end
        end else if (redir_s) begin
          // Request is outstanding, so PC_Out must hold; park the target.
          pend_target_d      = tgt_s;
          state_d            = REDIR_WAIT;
          redirect_pending_d = 1'b1;
          misaligned_d       = tgt_mis_s;
        end else begin
          pc_d = pc_q;
        end
      end
      REDIR_WAIT: begin
        if (fetch_ready) begin
          pc_d               = redir_s ? tgt_s : pend_target_q;
          misaligned_d       = redir_s ? tgt_mis_s : 1'b0;
          state_d            = RUN;
          redirect_pending_d = 1'b0;
        end else if (redir_s) begin
          pend_target_d = tgt_s;
          misaligned_d  = tgt_mis_s;
        end else begin
          pend_target_d = pend_target_q;
        end
      end
      default: begin
        state_d            = BOOT;
        fetch_valid_d      = 1'b0;
        redirect_pending_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q            <= BOOT;
      pc_q               <= RESET_VECTOR;
      pend_target_q      <= {PC_W{1'b0}};
      fetch_valid_q      <= 1'b0;
      redirect_pending_q <= 1'b0;
      misaligned_q       <= 1'b0;
    end else begin
      state_q            <= state_d;
      pc_q               <= pc_d;
      pend_target_q      <= pend_target_d;
      fetch_valid_q      <= fetch_valid_d;
      redirect_pending_q <= redirect_pending_d;
      misaligned_q       <= misaligned_d;
    end
  end

  assign PC_Out           = pc_q;
  assign fetch_valid      = fetch_valid_q;
  assign redirect_pending = redirect_pending_q;
  assign misaligned       = misaligned_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed scoreboard bench for pc_fetch_unit (PC_W=64, INSTR_BYTES=4, RESET_VECTOR=0).
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, trap, fetch_ready;
  logic [63:0] branch_target, trap_vector;
  logic        fetch_valid, redirect_pending, misaligned;
  logic [63:0] PC_Out, PC_Next_Seq;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [63:0] pc;
    logic        valid;
    logic        pend;
    logic        mis;
  } exp_t;

  exp_t sb[$];

  pc_fetch_unit #(.PC_W(64), .INSTR_BYTES(4), .RESET_VECTOR(64'h0)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .trap(trap), .trap_vector(trap_vector), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .PC_Out(PC_Out), .PC_Next_Seq(PC_Next_Seq),
    .redirect_pending(redirect_pending), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input string field, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp_v);
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge state, then compare after the edge.
  task automatic step(input string tag, input logic rst, input logic stl, input logic rdy,
                      input logic br, input logic [63:0] bt, input logic tr, input logic [63:0] tv,
                      input logic [63:0] e_pc, input logic e_valid, input logic e_pend, input logic e_mis);
    exp_t e;
    reset = rst; stall = stl; fetch_ready = rdy;
    branch_taken = br; branch_target = bt; trap = tr; trap_vector = tv;
    sb.push_back('{tag, e_pc, e_valid, e_pend, e_mis});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check(e.tag, "PC_Out", PC_Out, e.pc);
    check(e.tag, "PC_Next_Seq", PC_Next_Seq, e.pc + 64'd4);
    check(e.tag, "fetch_valid", {63'd0, fetch_valid}, {63'd0, e.valid});
    check(e.tag, "redirect_pending", {63'd0, redirect_pending}, {63'd0, e.pend});
    check(e.tag, "misaligned", {63'd0, misaligned}, {63'd0, e.mis});
  endtask

  localparam logic [63:0] Z = 64'h0;

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [63:0] MIS_PC  = 64'h40;
  localparam logic [63:0] MIS_NXT = 64'h44;
  localparam logic [63:0] Q_PC    = 64'h80;
  localparam logic        MIS_F   = 1'b1;
`else
  localparam logic [63:0] MIS_PC  = 64'h43;
  localparam logic [63:0] MIS_NXT = 64'h47;
  localparam logic [63:0] Q_PC    = 64'h81;
  localparam logic        MIS_F   = 1'b0;
`endif

  initial begin
    reset = 1'b0; stall = 1'b0; fetch_ready = 1'b1;
    branch_taken = 1'b0; branch_target = Z; trap = 1'b0; trap_vector = Z;

    // Reset, BOOT, then sequential fetch
    step("rst0",  1'b0, 1'b0, 1'b1, 1'b0, Z, 1'b0, Z, 64'h0, 1'b0, 1'b0, 1'b0);
    step("rst1",  1'b0, 1'b0, 1'b1, 1'b0, Z, 1'b0, Z, 64'h0, 1'b0, 1'b0, 1'b0);
    step("rst2",  1'b0, 1'b0, 1'b1, 1'b0, Z, 1'b0, Z, 64'h0, 1'b0, 1'b0, 1'b0);
    step("boot",  1'b1, 1'b0, 1'b1, 1'b1, 64'h700, 1'b0, Z, 64'h0, 1'b1, 1'b0, 1'b0);
    step("seq4",  1'b1, 1'b0, 1'b1, 1'b0, Z, 1'b0, Z, 64'h4, 1'b1, 1'b0, 1'b0);
    step("seq8",  1'b1, 1'b0, 1'b1, 1'b0, Z, 1'b0, Z, 64'h8, 1'b1, 1'b0, 1'b0);
    step("seqc",  1'b1, 1'b0, 1'b1, 1'b0, Z, 1'b0, Z, 64'hc, 1'b1, 1'b0, 1'b0);
    step("seq10", 1'b1, 1'b0, 1'b1, 1'b0, Z, 1'b0, Z, 64'h10, 1'b1, 1'b0, 1'b0);

    // Stall holds the address while the request keeps being re-issued
    step("stall1", 1'b1, 1'b1, 1'b1, 1'b0, Z, 1'b0, Z, 64'h10, 1'b1, 1'b0, 1'b0);
    step("stall2", 1'b1, 1'b1, 1'b1, 1'b0, Z, 1'b0, Z, 64'h10, 1'b1, 1'b0, 1'b0);
    step("unstall", 1'b1, 1'b0, 1'b1, 1'b0, Z, 1'b0, Z, 64'h14, 1'b1, 1'b0, 1'b0);

    // Trap beats branch and overrides stall
    step("prio",  1'b1, 1'b1, 1'b1, 1'b1, 64'h40, 1'b1, 64'h100, 64'h100, 1'b1, 1'b0, 1'b0);
    step("prio+", 1'b1, 1'b0, 1'b1, 1'b0, Z, 1'b0, Z, 64'h104, 1'b1, 1'b0, 1'b0);

    // Queued redirect, newest wins, released on first ready edge
    step("br20",  1'b1, 1'b0, 1'b1, 1'b1, 64'h20, 1'b0, Z, 64'h20, 1'b1, 1'b0, 1'b0);
    step("q_br",  1'b1, 1'b0, 1'b0, 1'b1, 64'h80, 1'b0, Z, 64'h20, 1'b1, 1'b1, 1'b0);
    step("q_tr",  1'b1, 1'b1, 1'b0, 1'b0, Z, 1'b1, 64'h200, 64'h20, 1'b1, 1'b1, 1'b0);
    step("q_hold", 1'b1, 1'b0, 1'b0, 1'b0, Z, 1'b0, Z, 64'h20, 1'b1, 1'b1, 1'b0);
    step("q_rel", 1'b1, 1'b1, 1'b1, 1'b0, Z, 1'b0, Z, 64'h200, 1'b1, 1'b0, 1'b0);
    step("q_seq", 1'b1, 1'b0, 1'b1, 1'b0, Z, 1'b0, Z, 64'h204, 1'b1, 1'b0, 1'b0);

    // Redirect present on the release edge takes precedence over the parked one
    step("q2_br", 1'b1, 1'b0, 1'b0, 1'b1, 64'h300, 1'b0, Z, 64'h204, 1'b1, 1'b1, 1'b0);
    step("q2_rel", 1'b1, 1'b0, 1'b1, 1'b1, 64'h400, 1'b0, Z, 64'h400, 1'b1, 1'b0, 1'b0);
    step("nordy", 1'b1, 1'b0, 1'b0, 1'b0, Z, 1'b0, Z, 64'h400, 1'b1, 1'b0, 1'b0);
    step("rdy",   1'b1, 1'b0, 1'b1, 1'b0, Z, 1'b0, Z, 64'h404, 1'b1, 1'b0, 1'b0);

    // Wrap modulo 2^64
    step("top",   1'b1, 1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, Z, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b0, 1'b0);
    step("wrap",  1'b1, 1'b0, 1'b1, 1'b0, Z, 1'b0, Z, 64'h0, 1'b1, 1'b0, 1'b0);

    // Reset while a redirect is parked
    step("w_br",  1'b1, 1'b0, 1'b0, 1'b1, 64'h500, 1'b0, Z, 64'h0, 1'b1, 1'b1, 1'b0);
    step("w_rst", 1'b0, 1'b0, 1'b1, 1'b0, Z, 1'b1, 64'h600, 64'h0, 1'b0, 1'b0, 1'b0);
    step("w_boot", 1'b1, 1'b0, 1'b1, 1'b1, 64'h800, 1'b0, Z, 64'h0, 1'b1, 1'b0, 1'b0);
    step("w_seq", 1'b1, 1'b0, 1'b1, 1'b0, Z, 1'b0, Z, 64'h4, 1'b1, 1'b0, 1'b0);

    // Misaligned targets: direct load and parked load
    step("mis",   1'b1, 1'b0, 1'b1, 1'b1, 64'h43, 1'b0, Z, MIS_PC, 1'b1, 1'b0, MIS_F);
    step("mis+",  1'b1, 1'b0, 1'b1, 1'b0, Z, 1'b0, Z, MIS_NXT, 1'b1, 1'b0, 1'b0);
    step("misq",  1'b1, 1'b0, 1'b0, 1'b0, Z, 1'b1, 64'h81, MIS_NXT, 1'b1, 1'b1, MIS_F);
    step("misq+", 1'b1, 1'b0, 1'b1, 1'b0, Z, 1'b0, Z, Q_PC, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
